// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : shared constants and types for the load/store unit.
// Revision 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   localparam int LSU_XLEN = 32;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ_LO  = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_REQ_HI  = 3'd3,
      ST_WAIT_HI = 3'd4,
      ST_DONE    = 3'd5
   } lsu_state_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } lsu_size_e;

   function automatic logic [3:0] base_mask(input logic [1:0] size);
      case (size)
         SIZE_BYTE: base_mask = 4'b0001;
         SIZE_HALF: base_mask = 4'b0011;
         default:   base_mask = 4'b1111;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
// lsu_load_align : extracts a load value from a two-word window and extends it.
// Revision 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_XLEN
) (
   input  logic [2*DATA_WIDTH-1:0] data_i,
   input  logic [1:0]              off_i,
   input  logic [2:0]              funct3_i,
   output logic [DATA_WIDTH-1:0]   data_o
);

   logic [DATA_WIDTH-1:0] win;

   always_comb begin
      win    = DATA_WIDTH'(data_i >> {off_i, 3'b000});
      data_o = win;
      case (funct3_i)
         FUNCT3_LB:  data_o = {{(DATA_WIDTH-8){win[7]}}, win[7:0]};
         FUNCT3_LH:  data_o = {{(DATA_WIDTH-16){win[15]}}, win[15:0]};
         FUNCT3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, win[7:0]};
         FUNCT3_LHU: data_o = {{(DATA_WIDTH-16){1'b0}}, win[15:0]};
         default:    data_o = win;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : MEM-stage initiator turning load/store requests into
//                   byte-enabled word beats, splitting misaligned accesses.
// Revision 1.0
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH       = LSU_XLEN,
   parameter int MEM_ADDR_WIDTH   = 30,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      re_i,
   input  logic                      we_i,
   input  logic [2:0]                funct3_i,
   input  logic [DATA_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i,
   output logic                      resp_valid_o,
   output logic                      resp_error_o,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]                mem_be_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   lsu_state_e state_q, state_d;

   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [DATA_WIDTH-1:0] hi_q, hi_d;
   logic [2:0]            funct3_q, funct3_d;
   logic                  we_q, we_d;
   logic                  misal_q, misal_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic [1:0]            req_off;
   logic                  req_misal;
   logic                  req_err;

   logic [MEM_ADDR_WIDTH-1:0] word_lo, word_hi;
   logic [7:0]                m8;
   logic [2*DATA_WIDTH-1:0]   d64;
   logic [DATA_WIDTH-1:0]     load_data;

   assign accept  = req_valid_i && (state_q == ST_IDLE);
   assign req_off = addr_i[1:0];

   always_comb begin
      req_misal = ((funct3_i[1:0] == SIZE_HALF) && (req_off == 2'd3)) ||
                  ((funct3_i[1:0] == SIZE_WORD) && (req_off != 2'd0));
      req_err   = (re_i && we_i) || (!re_i && !we_i) ||
                  (re_i && ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                            (funct3_i == 3'b111))) ||
                  (we_i && (funct3_i > FUNCT3_SW)) ||
                  (req_misal && !ALLOW_MISALIGNED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         misal_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         misal_q  <= misal_d;
         err_q    <= err_d;
      end
   end

   // Request fields latch at acceptance; read words latch on rvalid in WAIT.
   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      misal_d  = misal_q;
      err_d    = err_q;
      if (accept) begin
         addr_d   = addr_i;
         wdata_d  = wr_data_i;
         funct3_d = funct3_i;
         we_d     = we_i && !re_i;
         misal_d  = req_misal;
         err_d    = req_err;
         hi_d     = '0;
      end
      if ((state_q == ST_WAIT_LO) && mem_rvalid_i) lo_d = mem_rdata_i;
      if ((state_q == ST_WAIT_HI) && mem_rvalid_i) hi_d = mem_rdata_i;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = req_err ? ST_DONE : ST_REQ_LO;
         ST_REQ_LO:  if (mem_gnt_i) state_d = !we_q ? ST_WAIT_LO :
                                              (misal_q ? ST_REQ_HI : ST_DONE);
         ST_WAIT_LO: if (mem_rvalid_i) state_d = misal_q ? ST_REQ_HI : ST_DONE;
         ST_REQ_HI:  if (mem_gnt_i) state_d = we_q ? ST_DONE : ST_WAIT_HI;
         ST_WAIT_HI: if (mem_rvalid_i) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign word_lo = addr_q[MEM_ADDR_WIDTH+1:2];
   assign word_hi = word_lo + MEM_ADDR_WIDTH'(1);
   assign m8      = {4'b0000, base_mask(funct3_q[1:0])} << addr_q[1:0];
   assign d64     = {{DATA_WIDTH{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};

   lsu_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .data_i   ({hi_q, lo_q}),
      .off_i    (addr_q[1:0]),
      .funct3_i (funct3_q),
      .data_o   (load_data)
   );

   // Bus fields are forced to zero outside REQ states so idle outputs stay quiet.
   always_comb begin
      req_ready_o  = (state_q == ST_IDLE);
      resp_valid_o = 1'b0;
      resp_error_o = 1'b0;
      rd_data_o    = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_be_o     = 4'b0000;
      mem_wdata_o  = '0;
      case (state_q)
         ST_REQ_LO: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = word_lo;
            mem_be_o    = m8[3:0];
            mem_wdata_o = d64[DATA_WIDTH-1:0];
         end
         ST_REQ_HI: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = word_hi;
            mem_be_o    = m8[7:4];
            mem_wdata_o = d64[2*DATA_WIDTH-1:DATA_WIDTH];
         end
         ST_DONE: begin
            resp_valid_o = 1'b1;
            resp_error_o = err_q;
            rd_data_o    = err_q ? '0 : load_data;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed self-checking bench with a byte-lane memory model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        re = 1'b0, we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, wr_data = '0;
   logic        gnt_en = 1'b1, stray_rv = 1'b0;
   logic        model_rv = 1'b0;
   logic [31:0] model_rdata = '0;
   logic        mem_rvalid;

   logic        req_ready, resp_valid, resp_error, mem_req, mem_we;
   logic [31:0] rd_data, mem_wdata;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;

   logic        r2_ready, r2_resp_valid, r2_resp_error, r2_mem_req, r2_mem_we;
   logic [31:0] r2_rd_data, r2_mem_wdata;
   logic [29:0] r2_mem_addr;
   logic [3:0]  r2_mem_be;

   int total = 0;
   int bad   = 0;

   assign mem_rvalid = model_rv | stray_rv;

   always #5 clk = ~clk;

   load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .re_i(re), .we_i(we), .funct3_i(funct3), .addr_i(addr), .wr_data_i(wr_data),
      .resp_valid_o(resp_valid), .resp_error_o(resp_error), .rd_data_o(rd_data),
      .mem_req_o(mem_req), .mem_gnt_i(gnt_en), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(model_rdata)
   );

   load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
      .clk(clk), .rst(rst), .req_valid_i(req_valid2), .req_ready_o(r2_ready),
      .re_i(re), .we_i(we), .funct3_i(funct3), .addr_i(addr), .wr_data_i(wr_data),
      .resp_valid_o(r2_resp_valid), .resp_error_o(r2_resp_error), .rd_data_o(r2_rd_data),
      .mem_req_o(r2_mem_req), .mem_gnt_i(1'b1), .mem_we_o(r2_mem_we),
      .mem_addr_o(r2_mem_addr), .mem_be_o(r2_mem_be), .mem_wdata_o(r2_mem_wdata),
      .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0)
   );

   // Memory model: 256 words indexed by the low word-address bits, one-cycle read.
   logic [31:0] mem [0:255];
   int          beat_cnt = 0;
   int          req_cycles = 0;
   logic [29:0] log_addr [0:63];
   logic [3:0]  log_be   [0:63];
   logic [31:0] log_wd   [0:63];
   logic        log_we   [0:63];

   always @(posedge clk) begin : model
      logic [31:0] w;
      if (mem_req) req_cycles <= req_cycles + 1;
      model_rv <= 1'b0;
      if (mem_req && gnt_en) begin
         log_addr[beat_cnt % 64] <= mem_addr;
         log_be[beat_cnt % 64]   <= mem_be;
         log_wd[beat_cnt % 64]   <= mem_wdata;
         log_we[beat_cnt % 64]   <= mem_we;
         beat_cnt <= beat_cnt + 1;
         if (mem_we) begin
            w = mem[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr[7:0]] <= w;
         end else begin
            model_rv    <= 1'b1;
            model_rdata <= mem[mem_addr[7:0]];
         end
      end
   end

   task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid = 1'b1; re = r; we = w; funct3 = f3; addr = a; wr_data = d;
      @(negedge clk);
      req_valid = 1'b0; re = 1'b0; we = 1'b0;
   endtask

   // Returns cycles from acceptance to resp_valid, or -1 when none arrives.
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) lat = -1;
   endtask

   task automatic test_reset;
      logic [70:0] got;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      got = {req_ready, resp_valid, resp_error, rd_data, mem_req, mem_we, mem_addr, mem_be};
      total++;
      if (got !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 4'h0}) begin
         bad++; $display("FAIL reset_outputs got=%h exp=%h", got, {3'b100, 68'h0});
      end
      total++;
      if (mem_wdata !== 32'h0 || r2_ready !== 1'b1) begin
         bad++; $display("FAIL reset_wdata got=%h/%b exp=0/1", mem_wdata, r2_ready);
      end
   endtask

   task automatic test_store_word;
      int lat, b0;
      b0 = beat_cnt;
      issue(1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'hDEADBEEF);
      wait_resp(lat);
      total++;
      if (lat !== 2 || resp_error !== 1'b0) begin
         bad++; $display("FAIL sw_latency got=%0d err=%b exp=2 err=0", lat, resp_error);
      end
      total++;
      if (beat_cnt - b0 !== 1 ||
          {log_we[b0%64], log_addr[b0%64], log_be[b0%64], log_wd[b0%64]} !==
          {1'b1, 30'h40, 4'hF, 32'hDEADBEEF}) begin
         bad++; $display("FAIL sw_beat got=%0d %h %h %h exp=1 40 f deadbeef",
                         beat_cnt - b0, log_addr[b0%64], log_be[b0%64], log_wd[b0%64]);
      end
   endtask

   task automatic test_byte_lanes;
      int lat, b0;
      b0 = beat_cnt;
      issue(1'b0, 1'b1, FUNCT3_SB, 32'h103, 32'h000000A5);
      wait_resp(lat);
      total++;
      if (lat !== 2 || {log_we[b0%64], log_addr[b0%64], log_be[b0%64], log_wd[b0%64]} !==
          {1'b1, 30'h40, 4'b1000, 32'hA5000000}) begin
         bad++; $display("FAIL sb_beat got=lat%0d %h %b %h exp=lat2 40 1000 a5000000",
                         lat, log_addr[b0%64], log_be[b0%64], log_wd[b0%64]);
      end
      issue(1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'h80000000);
      wait_resp(lat);
      issue(1'b1, 1'b0, FUNCT3_LB, 32'h103, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 3 || rd_data !== 32'hFFFFFF80 || resp_error !== 1'b0) begin
         bad++; $display("FAIL lb_sign got=lat%0d %h exp=lat3 ffffff80", lat, rd_data);
      end
      issue(1'b1, 1'b0, FUNCT3_LBU, 32'h103, 32'h0);
      wait_resp(lat);
      total++;
      if (rd_data !== 32'h00000080) begin
         bad++; $display("FAIL lbu_zero got=%h exp=00000080", rd_data);
      end
      issue(1'b1, 1'b0, FUNCT3_LH, 32'h102, 32'h0);
      wait_resp(lat);
      total++;
      if (rd_data !== 32'hFFFF8000) begin
         bad++; $display("FAIL lh_sign got=%h exp=ffff8000", rd_data);
      end
   endtask

   task automatic test_misaligned_load;
      int lat, b0;
      issue(1'b0, 1'b1, FUNCT3_SW, 32'h0FC, 32'h11223344);
      wait_resp(lat);
      issue(1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'h55667788);
      wait_resp(lat);
      b0 = beat_cnt;
      issue(1'b1, 1'b0, FUNCT3_LW, 32'h0FE, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 5 || rd_data !== 32'h77881122) begin
         bad++; $display("FAIL lw_misal got=lat%0d %h exp=lat5 77881122", lat, rd_data);
      end
      total++;
      if (beat_cnt - b0 !== 2 ||
          {log_we[b0%64], log_addr[b0%64], log_be[b0%64]} !== {1'b0, 30'h3F, 4'b1100} ||
          {log_we[(b0+1)%64], log_addr[(b0+1)%64], log_be[(b0+1)%64]} !== {1'b0, 30'h40, 4'b0011}) begin
         bad++; $display("FAIL lw_misal_beats got=%0d %h/%b %h/%b exp=2 3f/1100 40/0011",
                         beat_cnt - b0, log_addr[b0%64], log_be[b0%64],
                         log_addr[(b0+1)%64], log_be[(b0+1)%64]);
      end
   endtask

   task automatic test_misaligned_store;
      int lat, b0;
      b0 = beat_cnt;
      issue(1'b0, 1'b1, FUNCT3_SH, 32'hFFFFFFFF, 32'h0000BEEF);
      wait_resp(lat);
      total++;
      if (lat !== 3 || beat_cnt - b0 !== 2) begin
         bad++; $display("FAIL sh_wrap_latency got=lat%0d beats%0d exp=lat3 beats2", lat, beat_cnt - b0);
      end
      total++;
      if ({log_we[b0%64], log_addr[b0%64], log_be[b0%64], log_wd[b0%64]} !==
          {1'b1, 30'h3FFFFFFF, 4'b1000, 32'hEF000000} ||
          {log_we[(b0+1)%64], log_addr[(b0+1)%64], log_be[(b0+1)%64], log_wd[(b0+1)%64]} !==
          {1'b1, 30'h0, 4'b0001, 32'h000000BE}) begin
         bad++; $display("FAIL sh_wrap_beats got=%h/%b/%h %h/%b/%h exp=3fffffff/1000/ef000000 0/0001/000000be",
                         log_addr[b0%64], log_be[b0%64], log_wd[b0%64],
                         log_addr[(b0+1)%64], log_be[(b0+1)%64], log_wd[(b0+1)%64]);
      end
      issue(1'b1, 1'b0, FUNCT3_LHU, 32'hFFFFFFFF, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 5 || rd_data !== 32'h0000BEEF) begin
         bad++; $display("FAIL lhu_wrap got=lat%0d %h exp=lat5 0000beef", lat, rd_data);
      end
   endtask

   task automatic test_errors;
      int lat, r0;
      r0 = req_cycles;
      issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 1 || resp_error !== 1'b1 || rd_data !== 32'h0) begin
         bad++; $display("FAIL err_ld011 got=lat%0d err%b %h exp=lat1 err1 0", lat, resp_error, rd_data);
      end
      issue(1'b1, 1'b1, FUNCT3_LW, 32'h0, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 1 || resp_error !== 1'b1) begin
         bad++; $display("FAIL err_re_we got=lat%0d err%b exp=lat1 err1", lat, resp_error);
      end
      issue(1'b0, 1'b0, FUNCT3_LW, 32'h0, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 1 || resp_error !== 1'b1) begin
         bad++; $display("FAIL err_no_op got=lat%0d err%b exp=lat1 err1", lat, resp_error);
      end
      issue(1'b0, 1'b1, 3'b100, 32'h0, 32'h0);
      wait_resp(lat);
      total++;
      if (lat !== 1 || resp_error !== 1'b1) begin
         bad++; $display("FAIL err_st100 got=lat%0d err%b exp=lat1 err1", lat, resp_error);
      end
      @(negedge clk);
      total++;
      if (req_cycles !== r0) begin
         bad++; $display("FAIL err_no_mem_req got=%0d exp=%0d", req_cycles, r0);
      end
      req_valid2 = 1'b1; re = 1'b1; we = 1'b0; funct3 = FUNCT3_LW; addr = 32'h2;
      @(negedge clk);
      req_valid2 = 1'b0; re = 1'b0;
      total++;
      if ({r2_resp_valid, r2_resp_error, r2_mem_req, r2_rd_data} !== {3'b110, 32'h0}) begin
         bad++; $display("FAIL strict_misal got=%b%b%b %h exp=110 0",
                         r2_resp_valid, r2_resp_error, r2_mem_req, r2_rd_data);
      end
   endtask

   task automatic test_stall_then_reset;
      int resp_seen;
      @(negedge clk);
      gnt_en = 1'b0;
      issue(1'b1, 1'b0, FUNCT3_LW, 32'h100, 32'h0);
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({mem_req, mem_we, mem_addr, mem_be, req_ready} !== {1'b1, 1'b0, 30'h40, 4'hF, 1'b0}) begin
            bad++; $display("FAIL stall_hold c%0d got=%b%b %h %b rdy%b exp=10 40 1111 rdy0",
                            c, mem_req, mem_we, mem_addr, mem_be, req_ready);
         end
         @(negedge clk);
      end
      gnt_en = 1'b1;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || req_ready !== 1'b0) begin
         bad++; $display("FAIL wait_lo got=req%b rdy%b exp=req0 rdy0", mem_req, req_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({req_ready, mem_req, resp_valid} !== 3'b100) begin
         bad++; $display("FAIL mid_reset got=%b exp=100", {req_ready, mem_req, resp_valid});
      end
      stray_rv = 1'b1;
      @(negedge clk);
      stray_rv = 1'b0;
      resp_seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (resp_valid) resp_seen++;
         @(negedge clk);
      end
      total++;
      if (resp_seen !== 0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL late_rvalid got=resp%0d rdy%b exp=resp0 rdy1", resp_seen, req_ready);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_byte_lanes();
      test_misaligned_load();
      test_misaligned_store();
      test_errors();
      test_stall_then_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
